// File: rtl/main_mem_resp.sv
// main_mem_resp
// Memory-side end of the cache-to-memory line handshake. Accepts one
// 128-bit line read or write, waits LATENCY cycles, then pulses
// mem2cache_ready for one cycle. On reads the line is returned on
// mem2cache_data, which holds until the next read response.
//
// Ports:
//   clk              in   1    rising-edge clock
//   r                in   1    asynchronous active-low reset
//   cache2mem_valid  in   1    request present
//   cache2mem_rw     in   1    0 = line read, 1 = line write
//   cache2mem_addr   in   32   byte address, line index in [4+LINE_AW-1:4]
//   cache2mem_data   in   128  write line (word 0 in [31:0])
//   mem2cache_data   out  128  read line, held between read responses
//   mem2cache_ready  out  1    one-cycle completion pulse
module main_mem_resp #(
    parameter int LINE_AW = 10,
    parameter int LATENCY = 3
) (
    input  logic         clk,
    input  logic         r,
    input  logic         cache2mem_valid,
    input  logic         cache2mem_rw,
    input  logic [31:0]  cache2mem_addr,
    input  logic [127:0] cache2mem_data,
    output logic [127:0] mem2cache_data,
    output logic         mem2cache_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [7:0] CNT_INIT     = 8'(LATENCY - 1);
    localparam bit         SINGLE_CYCLE = (LATENCY == 1);

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 rw_q, rw_d;
    logic [LINE_AW-1:0]   idx_q, idx_d;
    logic [127:0]         wline_q, wline_d;
    logic [127:0]         rdata_q, rdata_d;
    logic                 ready_q, ready_d;

    // Backing store: deliberately not reset, contents are X until written.
    logic [127:0]         mem_q [2**LINE_AW];

    logic [LINE_AW-1:0]   req_idx_s;
    logic [LINE_AW-1:0]   rd_idx_s;
    logic                 rd_is_read_s;
    logic                 mem_we_s;
    logic                 unused_addr_s;

    assign req_idx_s     = cache2mem_addr[4+LINE_AW-1:4];
    // Offset and tag bits do not select storage, so lines alias across them.
    assign unused_addr_s = ^{cache2mem_addr[31:4+LINE_AW], cache2mem_addr[3:0]};

    // State register.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cache2mem_valid) begin
                    state_d = SINGLE_CYCLE ? ST_RESP : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Counter value 1 marks the last WAIT cycle.
                if (cnt_q <= 8'd1) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and capture logic.
    always_comb begin
        cnt_d        = cnt_q;
        rw_d         = rw_q;
        idx_d        = idx_q;
        wline_d      = wline_q;
        rd_idx_s     = idx_q;
        rd_is_read_s = !rw_q;
        case (state_q)
            ST_IDLE: begin
                if (cache2mem_valid) begin
                    cnt_d        = CNT_INIT;
                    rw_d         = cache2mem_rw;
                    idx_d        = req_idx_s;
                    wline_d      = cache2mem_data;
                    // With LATENCY 1 the RESP entry edge is the acceptance
                    // edge, so the read must use the live request fields.
                    rd_idx_s     = req_idx_s;
                    rd_is_read_s = !cache2mem_rw;
                end else begin
                    rd_is_read_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 8'd1) begin
                    cnt_d = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: cnt_d = 8'd0;
            default: cnt_d = 8'd0;
        endcase

        ready_d = (state_d == ST_RESP);

        if ((state_d == ST_RESP) && (state_q != ST_RESP) && rd_is_read_s) begin
            rdata_d = mem_q[rd_idx_s];
        end else begin
            rdata_d = rdata_q;
        end

        // Writes commit on the edge leaving RESP.
        mem_we_s = (state_q == ST_RESP) && rw_q;
    end

    // Request capture, counter and registered outputs.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            cnt_q   <= 8'd0;
            rw_q    <= 1'b0;
            idx_q   <= '0;
            wline_q <= 128'h0;
            rdata_q <= 128'h0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            idx_q   <= idx_d;
            wline_q <= wline_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // Line storage write port.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[idx_q] <= wline_q;
        end
    end

    assign mem2cache_data  = rdata_q;
    assign mem2cache_ready = ready_q;

endmodule
